// File: rtl/mpd_prj_switch_ctrl.sv
// mpd_prj_switch_ctrl: sequences clock gating, reset and return-bus select when switching user projects.
// Optional project watchdog (prj_alive/wdt_fired) is built when MPD_PRJ_SWITCH_WDT_EN is defined.
module mpd_prj_switch_ctrl #(
    parameter int NUM_PRJ       = 4,
    parameter int SEL_W         = 2,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4
`ifdef MPD_PRJ_SWITCH_WDT_EN
    ,
    parameter int WDT_W         = 20
`endif
) (
    input  logic             fabric_clk,
    input  logic             resetb,
    input  logic             fabric_done,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
`ifdef MPD_PRJ_SWITCH_WDT_EN
    input  logic             prj_alive,
    output logic             wdt_fired,
`endif
    output logic             req_ready,
    output logic [SEL_W-1:0] cur_sel,
    output logic             prj_reset,
    output logic             clk_gate_en,
    output logic             busy,
    output logic             err_invalid,
    output logic [7:0]       switch_count
);
    localparam int CNT_MAX = RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {BOOT, IDLE, GATE, RESET, CLKRST} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] cap_q, cap_d, cur_sel_q;
    logic [7:0]       switch_count_q;
    logic             req_ready_q, prj_reset_q, clk_gate_en_q, busy_q, err_invalid_q;
    logic             accept, valid_sel, cnt_done, wdt_trip;

    assign accept    = req_valid && req_ready_q;
    assign valid_sel = int'(req_sel) < NUM_PRJ;
    assign cnt_done  = cnt_q == '0;

`ifdef MPD_PRJ_SWITCH_WDT_EN
    logic             alive_q, wdt_fired_q, toggle;
    logic [WDT_W-1:0] wdt_cnt_q;
    localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};

    assign toggle    = prj_alive ^ alive_q;
    // Trip on the cycle the counter would reach all-ones.
    assign wdt_trip  = state_q == IDLE && fabric_done && !toggle && wdt_cnt_q == WDT_LAST;
    assign wdt_fired = wdt_fired_q;

    always_ff @(posedge fabric_clk or negedge resetb) begin
        if (!resetb) begin
            alive_q     <= 1'b0;
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            alive_q     <= prj_alive;
            wdt_cnt_q   <= (state_q != IDLE || toggle) ? '0 : wdt_cnt_q + 1'b1;
            wdt_fired_q <= wdt_fired_q || wdt_trip;
        end
    end
`else
    assign wdt_trip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? cnt_q : cnt_q - 1'b1;
        cap_d   = cap_q;
        case (state_q)
            BOOT: if (fabric_done) begin
                state_d = CLKRST;
                cnt_d   = SETTLE_LD;
            end
            IDLE: if ((accept && valid_sel) || wdt_trip) begin
                state_d = GATE;
                cnt_d   = SETTLE_LD;
                cap_d   = (accept && valid_sel) ? req_sel : cur_sel_q;
            end
            GATE: if (cnt_done) begin
                state_d = RESET;
                cnt_d   = RST_LD;
            end
            RESET: if (cnt_done) begin
                state_d = CLKRST;
                cnt_d   = SETTLE_LD;
            end
            CLKRST: if (cnt_done) state_d = IDLE;
            default: state_d = BOOT;
        endcase
        // Losing fabric configuration abandons whatever is in flight.
        if (!fabric_done) state_d = BOOT;
    end

    always_ff @(posedge fabric_clk or negedge resetb) begin
        if (!resetb) begin
            state_q        <= BOOT;
            cnt_q          <= '0;
            cap_q          <= '0;
            cur_sel_q      <= '0;
            switch_count_q <= '0;
            req_ready_q    <= 1'b0;
            prj_reset_q    <= 1'b1;
            clk_gate_en_q  <= 1'b0;
            busy_q         <= 1'b1;
            err_invalid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cap_q          <= cap_d;
            cur_sel_q      <= (state_d == RESET && state_q != RESET) ? cap_q : cur_sel_q;
            switch_count_q <= (state_q == CLKRST && state_d == IDLE && switch_count_q != 8'hFF) ?
                              switch_count_q + 8'd1 : switch_count_q;
            req_ready_q    <= state_d == IDLE;
            prj_reset_q    <= state_d == BOOT || state_d == RESET || state_d == CLKRST;
            clk_gate_en_q  <= state_d == IDLE || state_d == CLKRST;
            busy_q         <= state_d != IDLE;
            err_invalid_q  <= state_q == IDLE && fabric_done && accept && !valid_sel;
        end
    end

    assign req_ready    = req_ready_q;
    assign cur_sel      = cur_sel_q;
    assign prj_reset    = prj_reset_q;
    assign clk_gate_en  = clk_gate_en_q;
    assign busy         = busy_q;
    assign err_invalid  = err_invalid_q;
    assign switch_count = switch_count_q;
endmodule

// File: tb/tb_mpd_prj_switch_ctrl.sv
// tb_mpd_prj_switch_ctrl: randomized bench for mpd_prj_switch_ctrl against a cycle-offset reference model.
module tb_mpd_prj_switch_ctrl;
    localparam int NUM_PRJ = 3;
    localparam int SEL_W   = 2;
    localparam int RST     = 16;
    localparam int SET     = 4;

    logic             fabric_clk = 1'b0;
    logic             resetb = 1'b1;
    logic             fabric_done = 1'b0;
    logic             req_valid = 1'b0;
    logic [SEL_W-1:0] req_sel = '0;
    logic             req_ready, prj_reset, clk_gate_en, busy, err_invalid;
    logic [SEL_W-1:0] cur_sel;
    logic [7:0]       switch_count;
`ifdef MPD_PRJ_SWITCH_WDT_EN
    logic             prj_alive = 1'b0;
    logic             wdt_fired;
`endif

    int n_chk = 0;
    int n_pass = 0;

    // Model: boot, idle, or t cycles into a switch sequence (t=1 is the cycle after accept).
    typedef enum {M_BOOT, M_IDLE, M_SEQ} mkind_t;
    mkind_t m_kind = M_BOOT;
    int     m_t = 0;
    int     m_cur = 0;
    int     m_cap = 0;
    int     m_cnt = 0;
    bit     m_err = 0;

    always #5 fabric_clk = ~fabric_clk;

    mpd_prj_switch_ctrl #(
        .NUM_PRJ(NUM_PRJ),
        .SEL_W(SEL_W),
        .RST_CYCLES(RST),
        .SETTLE_CYCLES(SET)
    ) dut (
        .fabric_clk(fabric_clk),
        .resetb(resetb),
        .fabric_done(fabric_done),
        .req_valid(req_valid),
        .req_sel(req_sel),
`ifdef MPD_PRJ_SWITCH_WDT_EN
        .prj_alive(prj_alive),
        .wdt_fired(wdt_fired),
`endif
        .req_ready(req_ready),
        .cur_sel(cur_sel),
        .prj_reset(prj_reset),
        .clk_gate_en(clk_gate_en),
        .busy(busy),
        .err_invalid(err_invalid),
        .switch_count(switch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_kind = M_BOOT;
        m_cur  = 0;
        m_cnt  = 0;
        m_err  = 0;
    endfunction

    function automatic void model_step();
        m_err = 0;
        if (!resetb) begin
            model_reset();
            return;
        end
        if (!fabric_done) begin
            m_kind = M_BOOT;
            return;
        end
        case (m_kind)
            M_BOOT: begin
                m_kind = M_SEQ;
                m_t    = SET + RST + 1;
            end
            M_IDLE: if (req_valid) begin
                if (int'(req_sel) < NUM_PRJ) begin
                    m_kind = M_SEQ;
                    m_t    = 1;
                    m_cap  = int'(req_sel);
                end else m_err = 1;
            end
            default: if (m_t == 2 * SET + RST) begin
                m_kind = M_IDLE;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_t++;
                if (m_t == SET + 1) m_cur = m_cap;
            end
        endcase
    endfunction

    task automatic compare_outputs();
        logic e_rst, e_gate;
        e_rst  = m_kind == M_BOOT ? 1'b1 : m_kind == M_SEQ ? (m_t > SET) : 1'b0;
        e_gate = m_kind == M_BOOT ? 1'b0 : m_kind == M_SEQ ? (m_t > SET + RST) : 1'b1;
        check("prj_reset", prj_reset, e_rst);
        check("clk_gate_en", clk_gate_en, e_gate);
        check("busy", busy, m_kind != M_IDLE);
        check("req_ready", req_ready, m_kind == M_IDLE);
        check("cur_sel", cur_sel, m_cur);
        check("err_invalid", err_invalid, m_err);
        check("switch_count", switch_count, m_cnt);
`ifdef MPD_PRJ_SWITCH_WDT_EN
        check("wdt_fired", wdt_fired, 0);
`endif
    endtask

    task automatic cycle();
        @(posedge fabric_clk);
        model_step();
        #1;
        compare_outputs();
`ifdef MPD_PRJ_SWITCH_WDT_EN
        prj_alive = ~prj_alive;
`endif
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && m_kind != M_IDLE; i++) cycle();
        check("idle_wait", m_kind == M_IDLE, 1);
    endtask

    task automatic request(input int sel);
        req_valid = 1'b1;
        req_sel   = SEL_W'(sel);
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        #1 resetb = 1'b0;
        #1 compare_outputs();
        repeat (3) cycle();
        resetb = 1'b1;
        repeat (50) cycle();
        fabric_done = 1'b1;
        repeat (6) cycle();
        check("boot_count", switch_count, 1);

        wait_idle();
        request(2);
        repeat (25) cycle();
        check("switch_to_2", cur_sel, 2);

        wait_idle();
        request(3);
        repeat (3) cycle();

        wait_idle();
        request(1);
        repeat (10) cycle();
        fabric_done = 1'b0;
        cycle();
        fabric_done = 1'b1;
        repeat (8) cycle();

        for (int i = 0; i < 3000; i++) begin
            fabric_done = $urandom_range(0, 199) != 0;
            req_valid   = $urandom_range(0, 3) == 0;
            req_sel     = SEL_W'($urandom_range(0, 3));
            cycle();
        end

        #2 resetb = 1'b0;
        model_reset();
        #1 compare_outputs();
        fabric_done = 1'b1;
        req_valid   = 1'b0;
        repeat (2) cycle();
        resetb = 1'b1;

        req_valid = 1'b1;
        req_sel   = SEL_W'(1);
        repeat (6600) cycle();
        req_valid = 1'b0;
        check("count_saturated", switch_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
